// File: rtl/start_fifo_pkg.sv
// Shared helpers for the start-token FIFO: counter width and
// legality check for the DEPTH / ADDR_WIDTH pairing.
package start_fifo_pkg;

  // The occupancy counter needs one bit more than the address so it can hold DEPTH itself.
  function automatic int cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // DEPTH must be at least 2 and must be addressable by ADDR_WIDTH bits.
  function automatic bit depth_legal(input int depth, input int addr_width);
    return (depth >= 2) && (depth <= (1 << addr_width));
  endfunction

endpackage

// File: rtl/start_fifo_srl_shiftreg.sv
// Addressable shift register used as start-token FIFO storage.
// New data enters entry 0, and older entries move up one slot on every write.
// There is no reset because the contents are only meaningful while the FIFO counts them.
module start_fifo_srl_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Shift every entry up by one and load the new token into entry 0.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < ENTRIES; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// Start-token FIFO controller. It keeps the occupancy count, the registered
// read address and the registered full/empty flags around an SRL-style
// shift register. Both the ap_fifo write side and the read side are
// gated by their clock enables.
module start_fifo_srl_ctrl
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam int CNT_W = cnt_w(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if (!depth_legal(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("start_fifo_srl_ctrl: DEPTH must be in 2 .. 2**ADDR_WIDTH");
  end

  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      next_count;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  // A push is refused while full and a pop while empty, even if the other side is active.
  assign push = if_write_ce & if_write & if_full_n;
  assign pop  = if_read_ce & if_read & if_empty_n;

  // Next occupancy and the head address that goes with it.
  // A simultaneous push and pop keeps both unchanged, because the shift moves the next entry into the head slot.
  always_comb begin
    next_count = count;
    next_addr  = '0;
    if (push && !pop) begin
      next_count = count + CNT_W'(1);
    end else if (pop && !push) begin
      next_count = count - CNT_W'(1);
    end
    if (next_count != '0) begin
      next_addr = ADDR_WIDTH'(next_count - CNT_W'(1));
    end
  end

  // Register the count, the address and the flags. The flags are derived from the next count, so they line up with the stored state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      addr       <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      count      <= next_count;
      addr       <= next_addr;
      if_empty_n <= (next_count != '0);
      if_full_n  <= (next_count != DEPTH_CNT);
    end
  end

  start_fifo_srl_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_shiftreg (
    .clk  (clk),
    .we   (push),
    .addr (addr),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Self-checking bench for start_fifo_srl_ctrl. A plain token queue serves as
// the reference FIFO, and directed steps are followed by random ce/request traffic.
module tb_start_fifo_srl_ctrl;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH      = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;

  logic [DATA_WIDTH-1:0] model_q[$];
  int errors = 0;
  int checks = 0;

  start_fifo_srl_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .if_full_n   (if_full_n),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Compare the flags and the head token against the reference queue.
  task automatic checkOutput(input string tag);
    logic exp_empty_n;
    logic exp_full_n;
    exp_empty_n = (model_q.size() != 0);
    exp_full_n  = (model_q.size() != DEPTH);
    checks++;
    assert (if_empty_n === exp_empty_n) else begin
      errors++;
      $error("[TB] FAIL %s empty_n: got %b expected %b", tag, if_empty_n, exp_empty_n);
    end
    checks++;
    assert (if_full_n === exp_full_n) else begin
      errors++;
      $error("[TB] FAIL %s full_n: got %b expected %b", tag, if_full_n, exp_full_n);
    end
    if (model_q.size() != 0) begin
      checks++;
      assert (if_dout === model_q[0]) else begin
        errors++;
        $error("[TB] FAIL %s dout: got %h expected %h", tag, if_dout, model_q[0]);
      end
    end
  endtask

  // Drive one cycle of requests, advance the reference FIFO by the same cycle, then check.
  task automatic applyStimulus(input logic wce, input logic w, input logic [DATA_WIDTH-1:0] d,
                               input logic rce, input logic r, input string tag);
    bit do_push;
    bit do_pop;
    if_write_ce = wce;
    if_write    = w;
    if_din      = d;
    if_read_ce  = rce;
    if_read     = r;
    do_push = wce && w && (model_q.size() < DEPTH);
    do_pop  = rce && r && (model_q.size() != 0);
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset       = 1'b1;
    if_write_ce = 1'b0;
    if_write    = 1'b0;
    if_din      = '0;
    if_read_ce  = 1'b0;
    if_read     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    reset = 1'b0;

    // Reading an empty FIFO is ignored.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "read_empty0");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "read_empty1");

    // Two pushes, then a push and a pop together, then drain the FIFO.
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, "push_a1");
    applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, "push_b2");
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, "push_pop_c3");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "pop_b2");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "pop_c3");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "pop_to_empty");

    // Fill the FIFO, then push once more; the extra push must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
    end
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, "write_full");
    // When the FIFO is full and both sides request, only the pop happens.
    applyStimulus(1'b1, 1'b1, 8'hDD, 1'b1, 1'b1, "full_wr_rd");

    // With a clock enable low, that side is frozen even though its request is high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "wce_low");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "rce_low");
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "drain");
    end

    // An asynchronous reset between clock edges while two entries are held.
    applyStimulus(1'b1, 1'b1, 8'h61, 1'b0, 1'b0, "pre_rst0");
    applyStimulus(1'b1, 1'b1, 8'h62, 1'b0, 1'b0, "pre_rst1");
    #2 reset = 1'b1;
    #1;
    model_q.delete();
    checkOutput("async_reset");
    #1 reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, "post_rst_push");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "post_rst_pop");

    // Random traffic: the first phase leans toward writes, the second toward reads.
    for (int i = 0; i < 400; i++) begin
      logic wce;
      logic w;
      logic rce;
      logic r;
      wce = ($urandom_range(0, 3) != 0);
      rce = ($urandom_range(0, 3) != 0);
      if (i < 200) begin
        w = ($urandom_range(0, 2) != 0);
        r = ($urandom_range(0, 2) == 0);
      end else begin
        w = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 2) != 0);
      end
      applyStimulus(wce, w, 8'($urandom), rce, r, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
